// File: rtl/weight_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : weight_serializer
//  Description : Parallel-to-serial converter feeding the bit-serial weight
//                FIFO. One-word holding register plus an LSB-first shifter.
//                Each word emits 1..16 bits according to its precision field.
//                FIFO backpressure stalls the shifter without losing bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module weight_serializer #(
    parameter int MAX_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAX_W-1:0] in_data,
    input  logic [3:0]       in_prec,
    input  logic             fifo_full,
    output logic             wr_en,
    output logic             din,
    output logic             busy,
    output logic             word_done
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    // Holding register: one word waiting for the shifter
    logic [MAX_W-1:0]   r_hold_data;
    logic [3:0]         r_hold_prec;
    logic               r_hold_v;

    // Shifter: bit 0 is always the next bit to emit
    logic [MAX_W-1:0]   r_sh_data;
    logic [4:0]         r_bits_left;
    logic               r_word_done;

    logic               w_accept;
    logic               w_load;
    logic               w_last;
    logic [4:0]         w_hold_bits;

    assign w_accept    = in_valid && !r_hold_v;
    // A precision code of zero stands for a full 16-bit word
    assign w_hold_bits = (r_hold_prec == 4'd0) ? 5'd16 : {1'b0, r_hold_prec};

    assign in_ready    = !r_hold_v;
    assign busy        = r_hold_v || (r_state == ST_SHIFT);
    assign word_done   = r_word_done;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, shifter load decision and serial outputs
    always_comb begin
        w_state_nxt = r_state;
        wr_en       = 1'b0;
        din         = 1'b0;
        w_load      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_hold_v) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                wr_en = !fifo_full;
                // din stays valid while stalled so the FIFO sees a stable bit
                din   = r_sh_data[0];
                if (!fifo_full && (r_bits_left == 5'd1)) begin
                    w_last = 1'b1;
                    // A waiting word is loaded on the same edge: no bubble
                    if (r_hold_v) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Holding register: a new accept wins over the drain into the shifter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_data <= '0;
            r_hold_prec <= '0;
            r_hold_v    <= 1'b0;
        end else if (w_accept) begin
            r_hold_data <= in_data;
            r_hold_prec <= in_prec;
            r_hold_v    <= 1'b1;
        end else if (w_load) begin
            r_hold_v    <= 1'b0;
        end
    end

    // Shifter: load from holding register or advance one bit per write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_data   <= '0;
            r_bits_left <= '0;
        end else if (w_load) begin
            r_sh_data   <= r_hold_data;
            r_bits_left <= w_hold_bits;
        end else if (wr_en) begin
            r_sh_data   <= {1'b0, r_sh_data[MAX_W-1:1]};
            r_bits_left <= r_bits_left - 5'd1;
        end
    end

    // One-cycle completion pulse following the last-bit write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_done <= 1'b0;
        end else begin
            r_word_done <= w_last;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_weight_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_weight_serializer
//  Description : Self-checking bench for weight_serializer. Expected bit
//                stream is built from accepted words (n LSBs, LSB first).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_serializer;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic [15:0] in_data   = '0;
    logic [3:0]  in_prec   = '0;
    logic        fifo_full = 1'b0;
    logic        in_ready;
    logic        wr_en;
    logic        din;
    logic        busy;
    logic        word_done;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;
    int done_cnt = 0;
    bit drv_done = 1'b0;

    bit wq[$];      // bits actually written into the FIFO
    int wcyc[$];    // cycle stamp of each write
    bit exp_q[$];   // reference bit stream

    weight_serializer #(.MAX_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_prec   (in_prec),
        .fifo_full (fifo_full),
        .wr_en     (wr_en),
        .din       (din),
        .busy      (busy),
        .word_done (word_done)
    );

    always #5 clk = ~clk;

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Capture every bit the FIFO will take at the next rising edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                wq.push_back(din);
                wcyc.push_back(cyc);
            end
            if (word_done) done_cnt <= done_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: a word contributes its n low bits, LSB first
    task automatic add_exp(input logic [15:0] d, input logic [3:0] p);
        int n;
        n = (p == 4'd0) ? 16 : int'(p);
        for (int i = 0; i < n; i++) exp_q.push_back(d[i]);
    endtask

    task automatic clear_sb();
        wq.delete();
        wcyc.delete();
        exp_q.delete();
    endtask

    // Caller is always 1 ns after a rising edge
    task automatic send_word(input logic [15:0] d, input logic [3:0] p);
        int t;
        t = 0;
        while (!in_ready && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 500) begin
            chk_cnt++;
            $display("FAIL send_timeout: in_ready=%0b expected 1 within 500 cycles", in_ready);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_prec  = p;
        add_exp(d, p);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_prec  = 4'($urandom);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || word_done) && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        chk_cnt++;
        if (t >= 3000) $display("FAIL idle_timeout: busy=%0b expected 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++;
        if ({in_ready, wr_en, din, busy, word_done} !== 5'b10000)
            $display("FAIL reset_outputs: got %b expected 10000",
                     {in_ready, wr_en, din, busy, word_done});
        else pass_cnt++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_cnt++;
        if ({in_ready, wr_en, busy} !== 3'b100)
            $display("FAIL reset_release: got %b expected 100", {in_ready, wr_en, busy});
        else pass_cnt++;
    endtask

    task automatic test_single();
        int d0, acc, bad;
        clear_sb();
        d0 = done_cnt;
        send_word(16'h00B5, 4'd8);
        acc = cyc;
        chk_cnt++;
        if ({in_ready, busy} !== 2'b01)
            $display("FAIL single_ready_after_accept: got %b expected 01", {in_ready, busy});
        else pass_cnt++;
        wait_idle();
        bad = 0;
        foreach (exp_q[i]) if (i >= wq.size() || wq[i] !== exp_q[i]) bad++;
        chk_cnt++;
        if (wq.size() != 8 || bad != 0)
            $display("FAIL single_stream: got %0d bits (%0d wrong) expected 8 bits", wq.size(), bad);
        else pass_cnt++;
        chk_cnt++;
        if (wcyc.size() != 8 || wcyc[0] != acc + 1 || wcyc[7] - wcyc[0] != 7)
            $display("FAIL single_timing: got %0d writes first at +%0d expected 8 contiguous at +1",
                     wcyc.size(), (wcyc.size() > 0) ? wcyc[0] - acc : -1);
        else pass_cnt++;
        chk_cnt++;
        if (done_cnt - d0 != 1)
            $display("FAIL single_done: got %0d pulses expected 1", done_cnt - d0);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int d0, bad;
        clear_sb();
        d0 = done_cnt;
        send_word(16'h000F, 4'd4);
        send_word(16'h0002, 4'd2);
        chk_cnt++;
        if (in_ready !== 1'b0)
            $display("FAIL b2b_ready_hold_full: got %0b expected 0", in_ready);
        else pass_cnt++;
        wait_idle();
        bad = 0;
        foreach (exp_q[i]) if (i >= wq.size() || wq[i] !== exp_q[i]) bad++;
        chk_cnt++;
        if (wq.size() != 6 || bad != 0)
            $display("FAIL b2b_stream: got %0d bits (%0d wrong) expected 6 bits", wq.size(), bad);
        else pass_cnt++;
        chk_cnt++;
        if (wcyc.size() != 6 || wcyc[5] - wcyc[0] != 5)
            $display("FAIL b2b_contiguous: got %0d writes expected 6 contiguous", wcyc.size());
        else pass_cnt++;
        chk_cnt++;
        if (done_cnt - d0 != 2)
            $display("FAIL b2b_done: got %0d pulses expected 2", done_cnt - d0);
        else pass_cnt++;
    endtask

    task automatic test_prec_boundary();
        int bad;
        clear_sb();
        send_word(16'hFFFF, 4'd0);
        wait_idle();
        bad = 0;
        foreach (exp_q[i]) if (i >= wq.size() || wq[i] !== exp_q[i]) bad++;
        chk_cnt++;
        if (wq.size() != 16 || bad != 0)
            $display("FAIL prec0_stream: got %0d bits (%0d wrong) expected 16 ones", wq.size(), bad);
        else pass_cnt++;
        clear_sb();
        send_word(16'hFFF0, 4'd4);
        wait_idle();
        bad = 0;
        foreach (exp_q[i]) if (i >= wq.size() || wq[i] !== exp_q[i]) bad++;
        chk_cnt++;
        if (wq.size() != 4 || bad != 0)
            $display("FAIL mask_stream: got %0d bits (%0d wrong) expected 4 zeros", wq.size(), bad);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        int bad, stall_bad;
        clear_sb();
        send_word(16'h0005, 4'd3);
        @(posedge clk); #1;
        chk_cnt++;
        if ({wr_en, din} !== 2'b11)
            $display("FAIL stall_first_bit: got %b expected 11", {wr_en, din});
        else pass_cnt++;
        @(posedge clk); #1;
        fifo_full = 1'b1;
        stall_bad = 0;
        for (int k = 0; k < 3; k++) begin
            #2;
            if ({wr_en, din} !== 2'b00) stall_bad++;
            @(posedge clk); #1;
        end
        fifo_full = 1'b0;
        chk_cnt++;
        if (stall_bad != 0)
            $display("FAIL stall_hold: got %0d bad stall cycles expected 0", stall_bad);
        else pass_cnt++;
        wait_idle();
        bad = 0;
        foreach (exp_q[i]) if (i >= wq.size() || wq[i] !== exp_q[i]) bad++;
        chk_cnt++;
        if (wq.size() != 3 || bad != 0)
            $display("FAIL stall_stream: got %0d bits (%0d wrong) expected 3 bits 1,0,1", wq.size(), bad);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int d0;
        clear_sb();
        d0 = done_cnt;
        send_word(16'h00B5, 4'd8);
        send_word(16'h1234, 4'd12);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({in_ready, wr_en, din, busy, word_done} !== 5'b10000)
            $display("FAIL midreset_outputs: got %b expected 10000",
                     {in_ready, wr_en, din, busy, word_done});
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk_cnt++;
        if (wq.size() != 3 || wq[0] !== 1'b1 || wq[1] !== 1'b0 || wq[2] !== 1'b1)
            $display("FAIL midreset_writes: got %0d writes expected 3 (1,0,1) and no more", wq.size());
        else pass_cnt++;
        chk_cnt++;
        if ({in_ready, busy} !== 2'b10 || done_cnt != d0)
            $display("FAIL midreset_idle: got ready/busy %b done %0d expected 10 done 0",
                     {in_ready, busy}, done_cnt - d0);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int d0, bad;
        int nwords;
        clear_sb();
        d0 = done_cnt;
        nwords = 40;
        drv_done = 1'b0;
        fork
            begin
                for (int w = 0; w < nwords; w++) begin
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk); #1;
                    end
                    send_word(16'($urandom), 4'($urandom_range(0, 15)));
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk); #1;
                    fifo_full = ($urandom_range(0, 99) < 30);
                end
            end
        join
        fifo_full = 1'b0;
        wait_idle();
        bad = 0;
        foreach (exp_q[i]) if (i >= wq.size() || wq[i] !== exp_q[i]) bad++;
        chk_cnt++;
        if (wq.size() != exp_q.size() || bad != 0)
            $display("FAIL random_stream: got %0d bits (%0d wrong) expected %0d bits",
                     wq.size(), bad, exp_q.size());
        else pass_cnt++;
        chk_cnt++;
        if (done_cnt - d0 != nwords)
            $display("FAIL random_done: got %0d pulses expected %0d", done_cnt - d0, nwords);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_prec_boundary();
        test_stall();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/weight_serializer.md
# weight_serializer

Parallel-to-serial converter upstream of the bit-serial weight FIFO in the FP-INT MAC datapath. Accepts integer weight words over a valid/ready handshake, buffers one word, and emits each word LSB-first as a 1-bit stream (`wr_en`/`din`) sized by a per-word precision. Honours FIFO backpressure through `fifo_full` and never drops or duplicates a bit.

## Interface
- `MAX_W`, 16: maximum word width and width of `in_data`. Fixed at 16 for this design.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: upstream word valid.
- `in_ready`  out  1: block can accept a word this cycle.
- `in_data`  in  16: weight word; only bits [n-1:0] are serialized.
- `in_prec`  in  4: bit count n for this word; 1..15 means n = value, 0 means n = 16. Sampled with the word.
- `fifo_full`  in  1: downstream FIFO full; blocks writes.
- `wr_en`  out  1: write strobe to FIFO (combinational).
- `din`  out  1: serial bit to FIFO (combinational).
- `busy`  out  1: shifter or holding register occupied.
- `word_done`  out  1: registered one-cycle pulse after a word's last bit is written.

## Operation
- Holding register (`hold_data`, `hold_prec`, `hold_v`) plus shifter (`sh_data`, `bits_left` 5-bit, state).
- `in_ready = !hold_v`. A handshake (`in_valid && in_ready`) at an edge loads the holding register and sets `hold_v`.
- States:
  - IDLE: shifter empty. If `hold_v`, load the shifter at the next edge, clear `hold_v` (unless a new word is accepted at the same edge), and go to SHIFT.
  - SHIFT: `wr_en = !fifo_full`, `din = sh_data[0]`. On each edge with `wr_en`, shift right by 1 and decrement `bits_left`.
  - Last bit (`wr_en && bits_left == 1`):
    - If `hold_v`, load the next word at that same edge and stay in SHIFT (no bubble).
    - Otherwise go to IDLE.
- Outside SHIFT, `wr_en = 0` and `din = 0`.
- Precision 0 loads `bits_left = 16`. Bits above n-1 are ignored and never emitted.
- Simultaneous accept and holding-register drain at one edge: the new word is stored, `hold_v` stays 1, and the drained word moves to the shifter.
- `fifo_full` high in SHIFT: `wr_en = 0`, and shifter, `bits_left` and `din` hold. `din` stays valid during the stall.
- `busy = hold_v || (state == SHIFT)`.
- `word_done` is set at the edge after a last-bit write and clears at the following edge. It pulses once per word, including back-to-back words.
- Reset (any time, including mid-word): state IDLE, `hold_v = 0`, `sh_data = 0`, `bits_left = 0`, `word_done = 0`. Any partial word is discarded.
- Reset values of outputs: `in_ready = 1`, `wr_en = 0`, `din = 0`, `busy = 0`, `word_done = 0`.

## Timing
- Word accepted at edge N with shifter idle: shifter loads at edge N+1. First bit is presented in cycle N+1..N+2 and written at edge N+2.
- With no stalls, an n-bit word occupies exactly n consecutive `wr_en` cycles.
- Back-to-back words with the holding register full: zero idle cycles between the last bit of word k and the first bit of word k+1.
- Throughput: 1 bit/cycle sustained when `fifo_full = 0` and upstream keeps the holding register filled.
- `word_done` is high in the cycle after the edge that wrote the last bit.
- `in_ready` deasserts in the cycle after an accept. It reasserts in the cycle after the holding register drains to the shifter.

## Test plan
- Reset, then accept `in_data = 0x00B5`, `in_prec = 8`, `fifo_full = 0` -> `wr_en` high for 8 consecutive cycles starting 2 edges after the accept. `din` sequence is 1,0,1,0,1,1,0,1. One `word_done` pulse follows.
- Two words back-to-back: `0x000F` with prec 4, then `0x0002` with prec 2 -> 6 contiguous `wr_en` cycles with bits 1,1,1,1,0,1 and two `word_done` pulses. `in_ready` low while the holding register is full.
- Accept `0xFFFF` with prec 0 -> exactly 16 writes, all 1. Upper-bit masking: `0xFFF0` with prec 4 -> exactly 4 writes, all 0.
- `0x0005` with prec 3, and `fifo_full` high for 3 cycles after the first write -> `wr_en` low for those 3 cycles with `din` stable at 0. Sequence resumes with 0,1, giving 3 writes total and no duplicates.
- Assert `rst_n = 0` after 3 of 8 bits, with a second word held -> outputs immediately at reset values. After release, `in_ready = 1`, `busy = 0`, and no further writes occur.
- Random words, precisions and `fifo_full` patterns against a scoreboard model -> bit stream matches exactly, and `word_done` count equals the accepted-word count.
